// File: rtl/analog_io_seq_ctrl_if.sv
// Wishbone-classic bus bundle for analog_io_seq_ctrl (slave side on the block).
interface analog_io_seq_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o
    );
endinterface

// File: rtl/analog_io_seq_ctrl.sv
// Break-before-make sequencer moving GPIO pads between digital and analog mode.
// Optional macro AIO_IRQ_EN: drives irq_o from the STATUS.done flag.
module analog_io_seq_ctrl #(
    parameter int unsigned          NUM_CH     = 6,
    parameter logic [31:0]          BASE_ADR   = 32'h3000_0100,
    parameter int unsigned          SETTLE_W   = 8,
    parameter logic [SETTLE_W-1:0]  SETTLE_DEF = SETTLE_W'(16),
    parameter logic [NUM_CH-1:0]    RESET_MODE = {NUM_CH{1'b1}}
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    analog_io_seq_ctrl_if.slave wbs,
    input  logic [NUM_CH-1:0]   dig_oeb_i,
    output logic [NUM_CH-1:0]   io_oeb,
    output logic [NUM_CH-1:0]   ana_en_o,
    output logic                busy_o,
    output logic                irq_o
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BREAK  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_MAKE   = 2'd3;

    logic [1:0]          r_state;
    logic [NUM_CH-1:0]   r_mode;
    logic [NUM_CH-1:0]   r_active;
    logic [NUM_CH-1:0]   r_ana;
    logic [NUM_CH-1:0]   r_chg;
    logic [NUM_CH-1:0]   r_tgt;
    logic [SETTLE_W-1:0] r_settle;
    logic [SETTLE_W-1:0] r_cnt;
    logic                r_done;
    logic                r_ack;
    logic [31:0]         r_dat;

    logic                w_req;
    logic                w_acc;
    logic                w_wr;
    logic [3:0]          w_off;
    logic                w_busy;
    logic                w_done_clr;
    logic [NUM_CH-1:0]   w_mode_wr;
    logic [SETTLE_W-1:0] w_settle_wr;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_req      = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:4] == BASE_ADR[31:4]);
    // Accept only when ack is low, so ack is a single-cycle pulse followed by a gap.
    assign w_acc      = w_req & ~r_ack;
    assign w_wr       = w_acc & wbs.wbs_we_i;
    assign w_off      = wbs.wbs_adr_i[3:0];
    assign w_busy     = (r_state != S_IDLE);
    assign w_done_clr = w_wr & (w_off == 4'h4) & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[1];
    assign w_unused   = &{1'b0, wbs.wbs_dat_i, wbs.wbs_sel_i};

    always_comb begin
        w_mode_wr   = r_mode;
        w_settle_wr = r_settle;
        for (int unsigned i = 0; i < NUM_CH; i++)
            if (wbs.wbs_sel_i[i/8]) w_mode_wr[i] = wbs.wbs_dat_i[i];
        for (int unsigned i = 0; i < SETTLE_W; i++)
            if (wbs.wbs_sel_i[i/8]) w_settle_wr[i] = wbs.wbs_dat_i[i];
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            4'h0:    w_rdata[NUM_CH-1:0]   = r_mode;
            4'h4:    w_rdata[1:0]          = {r_done, w_busy};
            4'h8:    w_rdata[NUM_CH-1:0]   = r_active;
            4'hC:    w_rdata[SETTLE_W-1:0] = r_settle;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_mode   <= RESET_MODE;
            r_settle <= SETTLE_DEF;
        end else begin
            r_ack <= w_acc;
            r_dat <= w_acc ? w_rdata : '0;
            if (w_wr && (w_off == 4'h0)) r_mode   <= w_mode_wr;
            if (w_wr && (w_off == 4'hC)) r_settle <= w_settle_wr;
        end
    end

    // Changing pads are latched and their switches opened on the edge into BREAK,
    // so io_oeb is already forced and ana_en_o already cleared during BREAK.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state  <= S_IDLE;
            r_active <= RESET_MODE;
            r_ana    <= RESET_MODE;
            r_chg    <= '0;
            r_tgt    <= RESET_MODE;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_mode != r_active) begin
                        r_state <= S_BREAK;
                        r_chg   <= r_mode ^ r_active;
                        r_tgt   <= r_mode;
                        r_ana   <= r_ana & ~(r_mode ^ r_active);
                        r_cnt   <= (r_settle == '0) ? SETTLE_W'(1) : r_settle;
                    end
                end
                S_BREAK:  r_state <= S_SETTLE;
                S_SETTLE: begin
                    if (r_cnt <= SETTLE_W'(1)) r_state <= S_MAKE;
                    else                       r_cnt   <= r_cnt - SETTLE_W'(1);
                end
                S_MAKE: begin
                    r_active <= r_tgt;
                    r_ana    <= r_tgt;
                    r_chg    <= '0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            if (r_state == S_MAKE) r_done <= 1'b1;
            else if (w_done_clr)   r_done <= 1'b0;
        end
    end

    assign io_oeb        = r_active | r_chg | dig_oeb_i;
    assign ana_en_o      = r_ana;
    assign busy_o        = w_busy;
    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;

`ifdef AIO_IRQ_EN
    assign irq_o = r_done;
`else
    assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_analog_io_seq_ctrl.sv
// Randomized bench for analog_io_seq_ctrl against a cycle-count reference model.
module tb_analog_io_seq_ctrl;
    localparam logic [31:0] BASE = 32'h3000_0100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] dig;
    logic [5:0] io;
    logic [5:0] ana;
    logic       busy;
    logic       irq;

    analog_io_seq_ctrl_if bus ();

    analog_io_seq_ctrl #(
        .NUM_CH(6), .BASE_ADR(BASE), .SETTLE_W(8), .SETTLE_DEF(8'd16), .RESET_MODE(6'h3F)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs(bus), .dig_oeb_i(dig),
        .io_oeb(io), .ana_en_o(ana), .busy_o(busy), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    // Reference model: register contents plus remaining cycles of the sequence in flight.
    logic [5:0]  m_mode, m_active, m_ana, m_tgt, m_chg;
    logic [7:0]  m_settle;
    logic        m_done, m_ack;
    logic [31:0] m_dat;
    int          m_left;
    bit          dig_rand = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 6'h3F; m_active = 6'h3F; m_ana = 6'h3F; m_tgt = 6'h3F; m_chg = '0;
        m_settle = 8'd16; m_done = 1'b0; m_ack = 1'b0; m_dat = '0; m_left = 0;
    endtask

    task automatic model_edge();
        logic        acc, clr, set;
        logic [31:0] rd;
        int          s;
        acc = bus.wbs_cyc_i && bus.wbs_stb_i && (bus.wbs_adr_i[31:4] == 28'h3000010) && !m_ack;
        case (bus.wbs_adr_i[3:0])
            4'h0:    rd = {26'd0, m_mode};
            4'h4:    rd = {30'd0, m_done, (m_left != 0)};
            4'h8:    rd = {26'd0, m_active};
            4'hC:    rd = {24'd0, m_settle};
            default: rd = '0;
        endcase
        set = 1'b0;
        if (m_left == 0) begin
            if (m_mode != m_active) begin
                s      = (m_settle == 0) ? 1 : int'(m_settle);
                m_chg  = m_mode ^ m_active;
                m_tgt  = m_mode;
                m_ana  = m_ana & ~m_chg;
                m_left = s + 2;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_active = m_tgt; m_ana = m_tgt; m_chg = '0; set = 1'b1;
            end
        end
        clr = acc && bus.wbs_we_i && (bus.wbs_adr_i[3:0] == 4'h4) && bus.wbs_sel_i[0] && bus.wbs_dat_i[1];
        m_done = set || (m_done && !clr);
        if (acc && bus.wbs_we_i && bus.wbs_sel_i[0]) begin
            if (bus.wbs_adr_i[3:0] == 4'h0) m_mode   = bus.wbs_dat_i[5:0];
            if (bus.wbs_adr_i[3:0] == 4'hC) m_settle = bus.wbs_dat_i[7:0];
        end
        m_ack = acc;
        m_dat = acc ? rd : '0;
    endtask

    task automatic check_all();
        logic exp_irq;
`ifdef AIO_IRQ_EN
        exp_irq = m_done;
`else
        exp_irq = 1'b0;
`endif
        chk("ack", bus.wbs_ack_o, m_ack);
        chk("dat", bus.wbs_dat_o, m_dat);
        chk("io_oeb", io, m_active | m_chg | dig);
        chk("ana_en", ana, m_ana);
        chk("busy", busy, m_left != 0);
        chk("irq", irq, exp_irq);
        chk("safe", ana & ~io, 0);
    endtask

    task automatic step();
        if (dig_rand) dig = 6'($urandom);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic wb(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input bit hold,
                      output logic acked, output logic [31:0] rdata);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_adr_i = adr;  bus.wbs_sel_i = sel;  bus.wbs_dat_i = dat;
        acked = 1'b0; rdata = '0;
        for (int k = 0; k < 3 && !acked; k++) begin
            step();
            if (bus.wbs_ack_o) begin acked = 1'b1; rdata = bus.wbs_dat_o; end
        end
        if (hold) step();
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        step();
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] dat);
        logic a; logic [31:0] d;
        wb(1'b1, BASE + {28'd0, off}, 4'hF, dat, 1'b0, a, d);
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] d);
        logic a;
        wb(1'b0, BASE + {28'd0, off}, 4'hF, '0, 1'b0, a, d);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((m_left != 0 || m_mode != m_active) && k < 400) begin step(); k++; end
        if (k >= 400) chk("wait_idle_bound", busy, 0);
    endtask

    initial begin
        logic [31:0] d, tmp;
        logic        a;
        logic [31:0] offs [6];
        offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h2, 32'h14};
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
        dig = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_io", io, 6'h3F);
        chk("rst_ana", ana, 6'h3F);
        rst_n = 1'b1;
        rd(4'h8, d); chk("rst_active", d, 32'h3F);
        rd(4'hC, d); chk("rst_settle", d, 32'd16);
        rd(4'h4, d); chk("rst_status", d, 32'h0);

        // Four low pads to digital with settle 4.
        wr(4'hC, 32'd4);
        wr(4'h0, 32'h30);
        wait_idle();
        rd(4'h8, d); chk("active_30", d, 32'h30);
        rd(4'h4, d); chk("status_done", d, 32'h2);
        chk("io_digital", io, 6'h30);

        // Settle 0 behaves as one cycle.
        wr(4'hC, 32'd0);
        wr(4'h0, 32'h3F);
        wait_idle();
        rd(4'h8, d); chk("active_3f", d, 32'h3F);
        chk("ana_3f", ana, 6'h3F);

        // Retarget during settle.
        wr(4'hC, 32'd6);
        wr(4'h0, 32'h00);
        repeat (2) step();
        wr(4'h0, 32'h3F);
        wait_idle();
        rd(4'h8, d); chk("active_retarget", d, 32'h3F);

        // Decode corners and byte selects.
        wb(1'b0, BASE + 32'h14, 4'hF, '0, 1'b0, a, d); chk("miss_ack", a, 0);
        wb(1'b0, BASE + 32'h2, 4'hF, '0, 1'b0, a, d);  chk("unmapped_ack", a, 1);
        chk("unmapped_dat", d, 0);
        wb(1'b1, BASE + 32'hC, 4'b0001, 32'h1234, 1'b0, a, d);
        rd(4'hC, d); chk("sel_settle", d, 32'h34);
        wb(1'b1, BASE + 32'hC, 4'b1110, 32'h0000_0005, 1'b0, a, d);
        rd(4'hC, d); chk("sel_ignored", d, 32'h34);

        // Clear done.
        wr(4'h4, 32'h2);
        rd(4'h4, d); chk("done_clr", d, 32'h0);

        // Reset in the middle of a sequence.
        wr(4'hC, 32'd8);
        wr(4'h0, 32'h0F);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Randomized traffic.
        dig_rand = 1'b1;
        for (int n = 0; n < 150; n++) begin
            tmp = $urandom;
            d = offs[$urandom_range(0, 5)];
            if (d == 32'hC) tmp[7:0] = 8'($urandom_range(0, 5));
            wb(1'($urandom), BASE + d, 4'($urandom), tmp, ($urandom_range(0, 3) == 0), a, d);
            repeat ($urandom_range(0, 6)) step();
        end
        wait_idle();
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
